// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizing helpers for the 2-requester burst arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int NUM_REQ = 2;

  // Beat counter width; a single bit is kept even when MAX_BURST is 1 or 2.
  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - single-bit 2:1 dataflow mux (s = 1 selects b)
module mux_2x1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/arb_mux_2x1_ctrl.sv
// rtl/arb_mux_2x1_ctrl.sv - round-robin burst arbiter driving a 2:1 valid/ready mux
module arb_mux_2x1_ctrl
  import arb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] in_valid,
  input  logic [NUM_REQ-1:0] in_last,
  input  logic [DW-1:0]      in_data0,
  input  logic [DW-1:0]      in_data1,
  output logic [NUM_REQ-1:0] in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               sel,
  output logic [NUM_REQ-1:0] grant
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_served_q, last_served_d;
  logic          sel_q, sel_d;

  logic [DW-1:0] mux_data;
  logic          mux_valid;
  logic          mux_last;
  logic          granted;
  logic          accept;
  logic          burst_end;
  logic          other_valid;

  for (genvar i = 0; i < DW; i++) begin : g_data_mux
    mux_2x1 u_mux_data (
      .a (in_data0[i]),
      .b (in_data1[i]),
      .s (sel_q),
      .y (mux_data[i])
    );
  end

  mux_2x1 u_mux_valid (
    .a (in_valid[0]),
    .b (in_valid[1]),
    .s (sel_q),
    .y (mux_valid)
  );

  mux_2x1 u_mux_last (
    .a (in_last[0]),
    .b (in_last[1]),
    .s (sel_q),
    .y (mux_last)
  );

  assign granted     = (state_q != IDLE);
  assign out_valid   = granted & mux_valid;
  assign out_last    = granted & mux_last;
  assign out_data    = mux_data;
  assign accept      = out_valid & out_ready;
  assign burst_end   = accept & (mux_last | (cnt_q == CNT_LAST));
  assign other_valid = sel_q ? in_valid[0] : in_valid[1];

  assign sel   = sel_q;
  assign grant = {state_q == GNT1, state_q == GNT0};

  always_comb begin
    in_ready = 2'b00;
    if (granted) begin
      in_ready = sel_q ? {out_ready, 1'b0} : {1'b0, out_ready};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        case (in_valid)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          2'b11:   state_d = last_served_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        if (burst_end) begin
          cnt_d         = '0;
          last_served_d = sel_q;
          // A limit-ended burst without last still has data queued, so it may keep the grant.
          if (other_valid) begin
            state_d = sel_q ? GNT0 : GNT1;
          end else if (!mux_last) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d = (state_d == GNT1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
      sel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
      sel_q         <= sel_d;
    end
  end

endmodule

// File: tb/tb_arb_mux_2x1_ctrl.sv
// tb/tb_arb_mux_2x1_ctrl.sv - directed self-checking bench for arb_mux_2x1_ctrl
module tb_arb_mux_2x1_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid;
  logic [1:0] in_last;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic [1:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       sel;
  logic [1:0] grant;

  int total = 0;
  int bad   = 0;

  arb_mux_2x1_ctrl #(.DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 2'b00;
    in_last   = 2'b00;
    in_data0  = 8'h00;
    in_data1  = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 2'b11;
    in_last   = 2'b00;
    out_ready = 1'b1;
    tick();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
    total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL reset_in_ready got=%b exp=00", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b exp=0", sel); end
    rst = 1'b0;
    tick();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", grant); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_first_sel got=%b exp=0", sel); end
  endtask

  task automatic test_single();
    logic [7:0] beats [3];
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    do_reset();
    in_valid  = 2'b10;
    in_data1  = beats[0];
    out_ready = 1'b1;
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_pre_grant got=%b exp=00", grant); end
    tick();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL single_grant got=%b exp=10", grant); end
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL single_sel got=%b exp=1", sel); end
    total++; if (in_ready !== 2'b10) begin bad++; $display("FAIL single_in_ready got=%b exp=10", in_ready); end
    for (int i = 0; i < 3; i++) begin
      in_data1 = beats[i];
      in_last  = (i == 2) ? 2'b10 : 2'b00;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid beat=%0d got=%b exp=1", i, out_valid); end
      total++; if (out_data !== beats[i]) begin bad++; $display("FAIL single_data beat=%0d got=%h exp=%h", i, out_data, beats[i]); end
      total++; if (out_last !== (i == 2)) begin bad++; $display("FAIL single_last beat=%0d got=%b exp=%b", i, out_last, (i == 2)); end
      tick();
    end
    in_valid = 2'b00;
    in_last  = 2'b00;
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_idle_grant got=%b exp=00", grant); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL single_idle_ready got=%b exp=00", in_ready); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    in_valid  = 2'b11;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      in_data0 = 8'(i);
      in_data1 = 8'(8'h80 | i);
      exp_g    = (i < 4 || i >= 8) ? 2'b01 : 2'b10;
      exp_d    = (i < 4 || i >= 8) ? 8'(i) : 8'(8'h80 | i);
      #1;
      total++; if (grant !== exp_g) begin bad++; $display("FAIL cont_grant cyc=%0d got=%b exp=%b", i, grant, exp_g); end
      total++; if (in_ready !== exp_g) begin bad++; $display("FAIL cont_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_g); end
      total++; if (out_data !== exp_d) begin bad++; $display("FAIL cont_data cyc=%0d got=%h exp=%h", i, out_data, exp_d); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cont_valid cyc=%0d got=%b exp=1", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 2'b10;
    tick();
    in_data1  = 8'hB1;
    out_ready = 1'b1;
    #1;
    total++; if (out_data !== 8'hB1) begin bad++; $display("FAIL bp_b1 got=%h exp=b1", out_data); end
    tick();
    in_data1  = 8'hB2;
    out_ready = 1'b0;
    in_valid  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=00", i, in_ready); end
      total++; if (grant !== 2'b10) begin bad++; $display("FAIL bp_grant cyc=%0d got=%b exp=10", i, grant); end
      total++; if (out_data !== 8'hB2) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=b2", i, out_data); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 2'b10) begin bad++; $display("FAIL bp_resume_ready got=%b exp=10", in_ready); end
    tick();
    in_data1 = 8'hB3;
    #1;
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL bp_grant_b3 got=%b exp=10", grant); end
    tick();
    in_data1 = 8'hB4;
    #1;
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL bp_grant_b4 got=%b exp=10", grant); end
    total++; if (out_data !== 8'hB4) begin bad++; $display("FAIL bp_data_b4 got=%h exp=b4", out_data); end
    tick();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL bp_handover got=%b exp=01", grant); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL bp_handover_sel got=%b exp=0", sel); end
  endtask

  task automatic test_last_early();
    do_reset();
    in_valid = 2'b01;
    in_data0 = 8'hD1;
    tick();
    in_valid  = 2'b11;
    in_data1  = 8'hE1;
    out_ready = 1'b1;
    tick();
    in_data0 = 8'hD2;
    in_last  = 2'b01;
    #1;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL last_grant_b2 got=%b exp=01", grant); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL last_flag got=%b exp=1", out_last); end
    tick();
    in_data0 = 8'hD3;
    in_last  = 2'b00;
    #1;
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL last_switch got=%b exp=10", grant); end
    total++; if (in_ready !== 2'b10) begin bad++; $display("FAIL last_r0_waits got=%b exp=10", in_ready); end
    total++; if (out_data !== 8'hE1) begin bad++; $display("FAIL last_r1_data got=%h exp=e1", out_data); end
    in_last = 2'b10;
    tick();
    in_last = 2'b00;
    #1;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL last_back_to_0 got=%b exp=01", grant); end
    total++; if (out_data !== 8'hD3) begin bad++; $display("FAIL last_r0_data got=%h exp=d3", out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 2'b10;
    in_data1 = 8'hC1;
    tick();
    out_ready = 1'b1;
    tick();
    in_data1 = 8'hC2;
    #2;
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL ar_pre_grant got=%b exp=10", grant); end
    rst = 1'b1;
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL ar_grant got=%b exp=00", grant); end
    total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL ar_ready got=%b exp=00", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL ar_sel got=%b exp=0", sel); end
    in_valid = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL ar_tie_grant got=%b exp=01", grant); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 2'b00;
    in_last   = 2'b00;
    in_data0  = 8'h00;
    in_data1  = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_last_early();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux_2x1_ctrl.md
Name: arb_mux_2x1_ctrl

Overview:
- Round-robin controller that shares one 2:1 datapath mux between two valid/ready requesters.
- Owns the mux select and gates per-requester ready.
- Holds a grant for a whole burst, ending on `last` or on a configurable beat limit, then rotates fairly.
- Sits directly in front of the 2:1 dataflow mux; drives its select and forwards the muxed beat downstream.

Parameters:
- DW, 8, data width of each requester and of the output.
- MAX_BURST, 4, maximum beats per grant (≥1); the grant is forcibly released after this many accepted beats.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  2  per-requester valid (bit 0 = requester 0)
- in_last  input  2  per-requester last-beat flag, qualified by in_valid
- in_data0  input  DW  requester 0 data
- in_data1  input  DW  requester 1 data
- in_ready  output  2  per-requester ready
- out_valid  output  1  muxed valid to the consumer
- out_data  output  DW  muxed data (sel ? in_data1 : in_data0)
- out_last  output  1  muxed last
- out_ready  input  1  consumer ready
- sel  output  1  mux select, registered (0 = requester 0)
- grant  output  2  one-hot current grant, 2'b00 when idle

Behaviour:
- Reset is asynchronous and active-high, on port rst; one clock, clk.
- Reset values:
  - state = IDLE, sel = 0, grant = 00, in_ready = 00, out_valid = 0, out_last = 0.
  - Burst count = 0; last_served = 1, so requester 0 wins the first tie.
- Reset asserted mid-burst aborts the grant immediately; no beat is accepted in that cycle.
- States: IDLE, GNT0, GNT1. sel = 1 only in GNT1; grant = {state==GNT1, state==GNT0}.
- IDLE:
  - out_valid = 0, in_ready = 00.
  - If only one in_valid bit is set, go to that requester's GNT.
  - If both are set, go to the requester that is NOT last_served.
  - Grant latency: one clock from request to grant.
- GNTx:
  - out_valid = in_valid[x], out_last = in_last[x], out_data = in_datax.
  - in_ready[x] = out_ready; the other ready bit is 0. All of these are combinational through the registered sel.
- Beat acceptance: a beat is accepted when in_valid[x] & out_ready.
  - Each accepted beat increments the burst count; count width = clog2(MAX_BURST), minimum 1.
  - Data is never duplicated or dropped; valid must not depend on ready.
- Grant end: occurs on an accepted beat with in_last[x] = 1, or on an accepted beat when count == MAX_BURST-1. At grant end:
  - count clears to 0 and last_served takes x.
  - Next state is GNT of the other requester if its in_valid is set in that cycle (zero-bubble handover).
  - Otherwise GNTx again if in_valid[x] is still set.
  - Otherwise IDLE.
- MAX_BURST = 1: every accepted beat ends the grant, giving strict per-beat alternation under contention.
- out_ready low: the grant and count hold and no state change occurs (backpressure).
- In_valid[x] dropping mid-burst without last: the grant is held (no timeout); out_valid = 0 until the requester resumes.
- The non-granted requester may assert valid at any time; it is never readied until granted.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; no requester waits more than one burst of the other.

Decomposition:
- Shared package arb_pkg holds:
  - state enum (IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2);
  - constant NUM_REQ = 2;
  - function for the count width.
- Sub-module: instantiate the existing mux_2x1 per data bit, plus one for last and one for valid, with s = sel, rather than re-coding the select.
- The arbitration FSM and counter stay in this module.

Test Plan:
- Reset: rst = 1 with in_valid = 11 → grant = 00, in_ready = 00, out_valid = 0. Release rst → GNT0 next clock, grant = 01, sel = 0.
- Single requester: in_valid = 10, data 0xA1..0xA3, last on the 3rd beat, out_ready = 1 → grant = 10 one clock later; out_data A1, A2, A3 on consecutive clocks; then IDLE.
- Contention with MAX_BURST = 4: both valid continuously with no last → 4 beats from 0, then 4 beats from 1, then 4 from 0, with no idle cycle between grants.
- Backpressure: in GNT1, out_ready = 0 for 3 clocks mid-burst → in_ready = 00, count holds, out_data stable. Resume → remaining beats delivered, count correct.
- Last ends early: requester 0 sends 2 beats with last on beat 2 while requester 1 is valid → grant switches to 10 the clock after beat 2; requester 0's next request waits.
- Async reset mid-burst: assert rst between clock edges during GNT1, beat 2 → outputs go to reset values without waiting for an edge; after release, a tie is resolved to requester 0.
